// File: rtl/sa_result_drain.sv
// Result unloader for the systolic array: snapshots the flattened MAC result bus on a
// capture strobe and streams it out one PE row per beat over a valid/ready interface.
module sa_result_drain #(
    parameter  int HPE   = 8,
    parameter  int VPE   = 8,
    parameter  int WIDTH = 32,
    localparam int PW    = 2 * WIDTH,
    localparam int ROW_W = PW * HPE,
    localparam int RW    = (VPE > 1) ? $clog2(VPE) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ROW_W*VPE-1:0]   i_y_in,
    input  logic                   i_cap,
    input  logic                   i_out_ready,
    output logic                   o_out_valid,
    output logic [ROW_W-1:0]       o_out_data,
    output logic [RW-1:0]          o_out_row,
    output logic                   o_out_last,
    output logic                   o_busy,
    output logic                   o_cap_drop
);

    // state    | meaning
    // S_IDLE   | no snapshot held, waiting for a capture strobe
    // S_STREAM | snapshot held, presenting row r_row to downstream
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(VPE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [ROW_W-1:0] r_shadow [VPE];
    logic [RW-1:0]    r_row;
    logic             r_cap_drop;
    logic             w_load;
    logic             w_adv;
    logic             w_wrap;
    logic             w_drop;
    logic             w_xfer;
    logic             w_last;

    assign w_last = (r_row == LAST_ROW);
    assign w_xfer = (r_state == S_STREAM) && i_out_ready;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        w_wrap = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cap) begin
                    w_load = 1'b1;
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                // A capture landing on the last-row transfer refills the store with no bubble.
                if (w_xfer && w_last) begin
                    w_wrap = 1'b1;
                    if (i_cap) begin
                        w_load = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_adv  = w_xfer;
                    w_drop = i_cap;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_cap_drop <= 1'b0;
            for (int r = 0; r < VPE; r++) begin
                r_shadow[r] <= '0;
            end
        end else begin
            r_state    <= w_next;
            r_cap_drop <= w_drop;
            if (w_load || w_wrap) begin
                r_row <= '0;
            end else if (w_adv) begin
                r_row <= r_row + RW'(1);
            end
            if (w_load) begin
                for (int r = 0; r < VPE; r++) begin
                    r_shadow[r] <= i_y_in[(VPE-r)*ROW_W-1 -: ROW_W];
                end
            end
        end
    end

    assign o_busy      = (r_state == S_STREAM);
    assign o_out_valid = o_busy;
    assign o_out_data  = o_busy ? r_shadow[r_row] : '0;
    assign o_out_row   = r_row;
    assign o_out_last  = o_busy && w_last;
    assign o_cap_drop  = r_cap_drop;

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: a 4x4 instance for the main scenarios and a
// 1x2 instance for the degenerate size.
module tb_sa_result_drain;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  row;
        logic        last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [255:0]  y1;
    logic          cap1, rdy1;
    logic          vld1, last1, busy1, drop1;
    logic [63:0]   data1;
    logic [1:0]    row1;
    logic [31:0]   y2;
    logic          cap2, rdy2;
    logic          vld2, last2, busy2, drop2;
    logic [15:0]   data2;
    logic [0:0]    row2;

    beat_t q1[$];
    beat_t q2[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    sa_result_drain #(.HPE(4), .VPE(4), .WIDTH(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_y_in(y1), .i_cap(cap1), .i_out_ready(rdy1),
        .o_out_valid(vld1), .o_out_data(data1), .o_out_row(row1), .o_out_last(last1),
        .o_busy(busy1), .o_cap_drop(drop1)
    );

    sa_result_drain #(.HPE(1), .VPE(2), .WIDTH(8)) u_dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_y_in(y2), .i_cap(cap2), .i_out_ready(rdy2),
        .o_out_valid(vld2), .o_out_data(data2), .o_out_row(row2), .o_out_last(last2),
        .o_busy(busy2), .o_cap_drop(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] elem(input int r, input int c);
        return {4'(r), 4'(c), 8'h00} + 16'(r * 4 + c);
    endfunction

    function automatic logic [255:0] pat_y();
        logic [255:0] y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                y[(16 - (r * 4 + c)) * 16 - 1 -: 16] = elem(r, c);
        return y;
    endfunction

    function automatic logic [63:0] pat_row(input int r);
        return {elem(r, 0), elem(r, 1), elem(r, 2), elem(r, 3)};
    endfunction

    task automatic push_pat();
        for (int r = 0; r < 4; r++) q1.push_back('{data: pat_row(r), row: 2'(r), last: (r == 3)});
    endtask

    task automatic push_ones();
        for (int r = 0; r < 4; r++) q1.push_back('{data: {64{1'b1}}, row: 2'(r), last: (r == 3)});
    endtask

    // Monitors: pop on every transfer, and require data to hold through consecutive stalls.
    bit          st1, st2;
    logic [63:0] pd1, pd2;
    logic [1:0]  pr1, pr2;

    always @(negedge clk) begin
        beat_t b;
        if (rst_n && vld1) begin
            if (rdy1) begin
                if (q1.size() == 0) chk("dut1_beat_expected", 64'(vld1), 64'd0);
                else begin
                    b = q1.pop_front();
                    chk("dut1_data", data1, b.data);
                    chk("dut1_row", 64'(row1), 64'(b.row));
                    chk("dut1_last", 64'(last1), 64'(b.last));
                end
                st1 = 1'b0;
            end else begin
                if (st1) begin
                    chk("dut1_stall_data", data1, pd1);
                    chk("dut1_stall_row", 64'(row1), 64'(pr1));
                end
                st1 = 1'b1;
                pd1 = data1;
                pr1 = row1;
            end
        end else st1 = 1'b0;
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst_n && vld2) begin
            if (rdy2) begin
                if (q2.size() == 0) chk("dut2_beat_expected", 64'(vld2), 64'd0);
                else begin
                    b = q2.pop_front();
                    chk("dut2_data", 64'(data2), b.data);
                    chk("dut2_row", 64'(row2), 64'(b.row));
                    chk("dut2_last", 64'(last2), 64'(b.last));
                end
                st2 = 1'b0;
            end else begin
                if (st2) chk("dut2_stall_data", 64'(data2), pd2);
                st2 = 1'b1;
                pd2 = 64'(data2);
                pr2 = 2'(row2);
            end
        end else st2 = 1'b0;
    end

    initial begin
        logic [6:0] seq;
        rst_n = 1'b0; cap1 = 1'b0; rdy1 = 1'b0; y1 = '0;
        cap2 = 1'b0; rdy2 = 1'b0; y2 = '0;
        #12;
        chk("rst_valid", 64'(vld1), 0);
        chk("rst_data", data1, 0);
        chk("rst_row", 64'(row1), 0);
        chk("rst_last", 64'(last1), 0);
        chk("rst_busy", 64'(busy1), 0);
        chk("rst_drop", 64'(drop1), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full-rate drain
        y1 = pat_y(); rdy1 = 1'b1; cap1 = 1'b1; push_pat();
        tick();
        cap1 = 1'b0;
        chk("lat_valid", 64'(vld1), 1);
        chk("lat_row", 64'(row1), 0);
        repeat (4) tick();
        chk("t1_valid_low", 64'(vld1), 0);
        chk("t1_q_empty", 64'(q1.size()), 0);

        // Stalled drain with Y_IN changed after capture
        rdy1 = 1'b0; cap1 = 1'b1; push_pat();
        tick();
        cap1 = 1'b0; y1 = {256{1'b1}};
        seq = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            rdy1 = seq[i];
            tick();
        end
        chk("t2_valid_low", 64'(vld1), 0);
        chk("t2_q_empty", 64'(q1.size()), 0);

        // Rejected capture mid-stream
        y1 = pat_y(); rdy1 = 1'b1; cap1 = 1'b1; push_pat();
        tick();
        cap1 = 1'b0;
        tick();
        y1 = {256{1'b1}}; cap1 = 1'b1;
        tick();
        cap1 = 1'b0;
        chk("t3_drop_pulse", 64'(drop1), 1);
        tick();
        chk("t3_drop_clear", 64'(drop1), 0);
        chk("t3_busy_row3", 64'(busy1), 1);
        tick();
        chk("t3_busy_low", 64'(busy1), 0);

        // Back-to-back capture on the last beat
        y1 = pat_y(); cap1 = 1'b1; push_pat();
        tick();
        cap1 = 1'b0;
        repeat (3) tick();
        y1 = {256{1'b1}}; cap1 = 1'b1; push_ones();
        tick();
        cap1 = 1'b0;
        chk("t4_valid", 64'(vld1), 1);
        chk("t4_row", 64'(row1), 0);
        chk("t4_data", data1, {64{1'b1}});
        chk("t4_no_drop", 64'(drop1), 0);
        repeat (4) tick();
        chk("t4_valid_low", 64'(vld1), 0);

        // Asynchronous reset mid-stream
        y1 = pat_y(); cap1 = 1'b1; push_pat();
        tick();
        cap1 = 1'b0;
        repeat (2) tick();
        chk("t5_row2", 64'(row1), 2);
        rdy1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(vld1), 0);
        chk("t5_async_busy", 64'(busy1), 0);
        q1.delete();
        repeat (2) tick();
        rst_n = 1'b1; rdy1 = 1'b1;
        repeat (5) tick();
        chk("t5_no_beats", 64'(vld1), 0);

        // Degenerate 1x2 array with back-to-back capture
        y2 = {16'hA1B2, 16'hC3D4}; rdy2 = 1'b1; cap2 = 1'b1;
        q2.push_back('{data: 64'hA1B2, row: 2'd0, last: 1'b0});
        q2.push_back('{data: 64'hC3D4, row: 2'd1, last: 1'b1});
        tick();
        cap2 = 1'b0;
        tick();
        chk("t6_last", 64'(last2), 1);
        y2 = {16'h1111, 16'h2222}; cap2 = 1'b1;
        q2.push_back('{data: 64'h1111, row: 2'd0, last: 1'b0});
        q2.push_back('{data: 64'h2222, row: 2'd1, last: 1'b1});
        tick();
        cap2 = 1'b0;
        chk("t6_b2b_valid", 64'(vld2), 1);
        chk("t6_b2b_row", 64'(row2), 0);
        chk("t6_b2b_no_drop", 64'(drop2), 0);
        repeat (2) tick();
        chk("t6_valid_low", 64'(vld2), 0);
        chk("t6_q_empty", 64'(q2.size()), 0);
        chk("q1_empty_end", 64'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Result unloader for the output-stationary 2D systolic array. It snapshots the array's flattened MAC result bus on a capture strobe. It then streams the snapshot out one PE row per beat over a valid/ready interface, so downstream logic (memory writer, accumulator, host bridge) reads results at its own pace while the array starts the next tile.

## Interface
- HPE, 8, horizontal PEs per row (elements per output beat)
- VPE, 8, PE rows (beats per snapshot); must be ≥ 2
- WIDTH, 32, operand width; each result element is PW = 2*WIDTH bits
- CLK  input  1  rising-edge clock
- RST  input  1  reset, asynchronous, active-low
- Y_IN  input  PW*HPE*VPE  flattened array results; element (r,c) at bits [(N-(r*HPE+c))*PW-1 : (N-(r*HPE+c+1))*PW], N=HPE*VPE (element (0,0) most significant)
- CAP  input  1  capture strobe; one-cycle pulse when Y_IN is final
- OUT_READY  input  1  downstream accepts a beat
- OUT_VALID  output  1  OUT_DATA holds a valid row
- OUT_DATA  output  PW*HPE  row r; element (r,c) at bits [(HPE-c)*PW-1 : (HPE-c-1)*PW] (column 0 most significant)
- OUT_ROW  output  max(1,$clog2(VPE))  index r of the current beat
- OUT_LAST  output  1  high with OUT_VALID when r = VPE-1
- BUSY  output  1  snapshot held, not fully drained
- CAP_DROP  output  1  one-cycle pulse when a CAP is rejected

## Operation
- Two states: IDLE and STREAM. Reset enters IDLE.
- IDLE: on CAP=1, register all of Y_IN into the shadow store. Set row=0 and enter STREAM.
- STREAM: OUT_VALID=1. OUT_DATA is shadow row `row`. OUT_ROW=row. OUT_LAST=(row==VPE-1).
- Beat transfers on a cycle with OUT_VALID & OUT_READY. After a non-last transfer, row increments.
- Last-row transfer with CAP=0: return to IDLE.
- Last-row transfer with CAP=1 in the same cycle: accept the new snapshot, set row=0, stay in STREAM. This gives back-to-back operation with no bubble.
- CAP in STREAM without a last-row transfer in that cycle: the snapshot is not altered. CAP_DROP pulses high on the next cycle.
- Without a transfer, OUT_DATA, OUT_ROW and OUT_LAST hold stable while OUT_VALID=1. Changes on Y_IN after capture never reach OUT_DATA.
- BUSY = (state==STREAM).
- Data is passed bit-exact. There is no arithmetic, sign handling or reordering within a row.
- The shadow store may be a random-indexed register or a row shift register. The externally visible beat sequence must be identical either way.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_ROW=0, OUT_LAST=0, BUSY=0, CAP_DROP=0. The shadow store is cleared to 0.
- RST asserted mid-stream: outputs return to reset values immediately (asynchronously). The snapshot is discarded.
- Latency: CAP sampled at edge k gives OUT_VALID=1 with row 0 after edge k, i.e. visible in cycle k+1.
- Throughput: with OUT_READY held 1, VPE beats in VPE consecutive cycles.
- OUT_VALID falls the cycle after the last transfer, unless a simultaneous CAP was accepted.
- OUT_VALID never depends combinationally on OUT_READY. All outputs are registered or decoded from registered state.
- CAP_DROP is registered: one cycle after the rejected CAP.

## Test plan
- Bench parameters HPE=VPE=4, WIDTH=8. Element (r,c) = 16'h{r}{c}00 + r*4 + c. Capture with OUT_READY=1 -> 4 consecutive beats. Row 0 = 64'h0000_0101_0202_0303 (column order 0..3, column 0 MS). OUT_ROW 0..3. OUT_LAST only on beat 3. OUT_VALID low afterwards.
- Same snapshot, OUT_READY toggling 1,0,0,1,0,1,1 -> exactly 4 transfers in order. OUT_DATA stable through stalls. Y_IN changed to all-ones after CAP never appears on the output.
- CAP pulsed during beat 1 of a stream -> CAP_DROP=1 one cycle later. Stream continues with the original rows 1..3. BUSY falls after row 3.
- CAP asserted on the same cycle as the row-3 transfer, with Y_IN = 16'hFFFF everywhere -> next cycle OUT_VALID=1, OUT_ROW=0, OUT_DATA=64'hFFFF_FFFF_FFFF_FFFF. No bubble and no CAP_DROP.
- RST driven low mid-stream at row 2 -> OUT_VALID/BUSY drop to 0 without waiting for a clock. After release, no beats appear until a new CAP.
- Degenerate size VPE=2, HPE=1 -> two beats. OUT_LAST on the second beat. Back-to-back CAP is accepted on the last beat.
